regfile_sb: RTL and testbench

Parametrised multi-port register file with an integrated scoreboard, replacing the single-write register file in the CPU datapath. It provides NREAD combinational read ports and two write ports (ALU and load write-back), with register 0 hardwired to zero and same-cycle write-to-read bypass. A per-register busy bit tracks results still in flight, so the decode stage can stall on read-after-write hazards without a separate hazard unit.

---
 rtl/regfile_sb.sv | 96 +++++++++
 tb/tb_regfile_sb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with per-register busy scoreboard
// Optional REGFILE_SB_BYPASS_EN: same-cycle write-to-read forwarding and rbusy masking.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREAD*ADDR_W-1:0]   ra,
    output logic [NREAD*DATA_W-1:0]   rd,
    output logic [NREAD-1:0]          rbusy,
    input  logic                      we0,
    input  logic [ADDR_W-1:0]         wa0,
    input  logic [DATA_W-1:0]         wd0,
    input  logic                      we1,
    input  logic [ADDR_W-1:0]         wa1,
    input  logic [DATA_W-1:0]         wd1,
    input  logic                      issue_en,
    input  logic [ADDR_W-1:0]         issue_rd,
    output logic [ADDR_W:0]           pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W:0]   pend_nxt;

    // A new producer supersedes a retiring one, so set takes priority over clear.
    always_comb begin
        busy_nxt = '0;
        pend_nxt = '0;
        for (int r = 1; r < DEPTH; r++) begin
            if (issue_en && issue_rd == ADDR_W'(r)) begin
                busy_nxt[r] = 1'b1;
            end else if ((we0 && wa0 == ADDR_W'(r)) || (we1 && wa1 == ADDR_W'(r))) begin
                busy_nxt[r] = 1'b0;
            end else begin
                busy_nxt[r] = busy[r];
            end
            pend_nxt = pend_nxt + {{ADDR_W{1'b0}}, busy_nxt[r]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            if (we0 && wa0 != '0) begin
                regs[wa0] <= wd0;
            end
            // Port 1 is written last so it wins a same-address collision.
            if (we1 && wa1 != '0) begin
                regs[wa1] <= wd1;
            end
            busy     <= busy_nxt;
            pend_cnt <= pend_nxt;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign addr = ra[i*ADDR_W +: ADDR_W];

        always_comb begin
            data = regs[addr];
            bsy  = busy[addr];
`ifdef REGFILE_SB_BYPASS_EN
            if (we1 && wa1 == addr) begin
                data = wd1;
                bsy  = 1'b0;
            end else if (we0 && wa0 == addr) begin
                data = wd0;
                bsy  = 1'b0;
            end
`endif
            if (addr == '0) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rd[i*DATA_W +: DATA_W] = data;
        assign rbusy[i]               = bsy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed vector bench for regfile_sb
// Expectations follow REGFILE_SB_BYPASS_EN when it is defined.
module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [14:0] ra;
    logic [95:0] rd;
    logic [2:0]  rbusy;
    logic        we0, we1, issue_en;
    logic [4:0]  wa0, wa1, issue_rd;
    logic [31:0] wd0, wd1;
    logic [5:0]  pend_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(3)) dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .issue_en(issue_en), .issue_rd(issue_rd), .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ie;
        logic [4:0]  ird;
        logic [4:0]  ra0, ra1, ra2;
        logic [31:0] e0, e1, e2;
        logic [2:0]  eb;
        logic [5:0]  ep;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic w0, input logic [4:0] a0, input logic [31:0] d0,
        input logic w1, input logic [4:0] a1, input logic [31:0] d1,
        input logic ie, input logic [4:0] ird,
        input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
        input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
        input logic [2:0] eb, input logic [5:0] ep);
        vec_t v;
        v.we0 = w0; v.wa0 = a0; v.wd0 = d0;
        v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
        v.ie = ie; v.ird = ird;
        v.ra0 = r0; v.ra1 = r1; v.ra2 = r2;
        v.e0 = e0; v.e1 = e1; v.e2 = e2;
        v.eb = eb; v.ep = ep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        issue_en = 1'b0; issue_rd = '0;
    endtask

    task automatic drive(input vec_t v);
        we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0;
        we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
        issue_en = v.ie; issue_rd = v.ird;
        ra = {v.ra2, v.ra1, v.ra0};
    endtask

    initial begin
        // we0 wa0 wd0 | we1 wa1 wd1 | ie ird | ra0 ra1 ra2 | exp rd0 rd1 rd2 | rbusy | pend
        vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 5,
                          0, 0, BYP ? 32'hDEADBEEF : 32'h0, 3'b000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 32'hDEADBEEF, 3'b000, 0));
        vecs.push_back(mk(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 32'hDEADBEEF, 3'b000, 0));
        vecs.push_back(mk(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 0, 0,
                          BYP ? 32'h22 : 32'h0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 32'h22, 0, 0, 3'b000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 0, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 3'b010, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3, 32'h33, 0, 0, 0, 3, 0,
                          0, BYP ? 32'h33 : 32'h0, 0, BYP ? 3'b000 : 3'b010, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 32'h33, 0, 3'b000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4, 4, 0, 0, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(1, 4, 32'h44, 0, 0, 0, 1, 4, 4, 0, 0,
                          BYP ? 32'h44 : 32'h0, 0, 0, BYP ? 3'b000 : 3'b001, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 32'h44, 0, 0, 3'b001, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 32'h44, 0, 0, 3'b001, 1));
        vecs.push_back(mk(1, 9, 32'h99, 1, 4, 32'h40, 0, 0, 4, 9, 0,
                          BYP ? 32'h40 : 32'h44, BYP ? 32'h99 : 32'h0, 0,
                          BYP ? 3'b000 : 3'b001, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 9, 5, 32'h40, 32'h99, 32'hDEADBEEF, 3'b000, 0));

        // Power-on reset
        rst = 1'b1;
        ra = '0;
        idle();
        #1;
        chk("reset_pend", 96'(pend_cnt), 96'd0);
        chk("reset_rbusy", 96'(rbusy), 96'd0);
        chk("reset_rd", rd, 96'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d_rd", i), rd, {vecs[i].e2, vecs[i].e1, vecs[i].e0});
            chk($sformatf("vec%0d_rbusy", i), 96'(rbusy), 96'(vecs[i].eb));
            chk($sformatf("vec%0d_pend", i), 96'(pend_cnt), 96'(vecs[i].ep));
        end

        // Fill the scoreboard with every nonzero register
        ra = '0;
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            idle();
            issue_en = 1'b1;
            issue_rd = 5'(r);
        end
        // Retire two per cycle; pend_cnt steps 31, 29, ..., 1
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk($sformatf("drain_pend_k%0d", k), 96'(pend_cnt), 96'(33 - 2 * k));
            idle();
            we0 = 1'b1; wa0 = 5'(2 * k - 1); wd0 = 32'h100 + 32'(2 * k - 1);
            we1 = 1'b1; wa1 = 5'(2 * k);     wd1 = 32'h100 + 32'(2 * k);
        end
        @(negedge clk);
        chk("drain_pend_last", 96'(pend_cnt), 96'd1);
        idle();
        we0 = 1'b1; wa0 = 5'd31; wd0 = 32'h11F;
        @(negedge clk);
        chk("drain_pend_zero", 96'(pend_cnt), 96'd0);
        idle();
        we0 = 1'b1; wa0 = 5'd1; wd0 = 32'h101;
        we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h102;
        @(negedge clk);
        chk("no_underflow", 96'(pend_cnt), 96'd0);

        // Mid-cycle asynchronous reset with busy registers and nonzero data
        idle();
        issue_en = 1'b1; issue_rd = 5'd3;
        @(negedge clk);
        issue_rd = 5'd5;
        @(negedge clk);
        idle();
        ra = {5'd3, 5'd5, 5'd31};
        #1;
        chk("pre_rst_pend", 96'(pend_cnt), 96'd2);
        chk("pre_rst_rd", rd, {32'h103, 32'h105, 32'h11F});
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_pend", 96'(pend_cnt), 96'd0);
        for (int a = 0; a < 32; a++) begin
            ra = {5'(a), 5'(a), 5'(a)};
            #1;
            chk($sformatf("rst_rd_a%0d", a), rd, 96'd0);
            chk($sformatf("rst_rbusy_a%0d", a), 96'(rbusy), 96'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        ra = {5'd3, 5'd5, 5'd31};
        #1;
        chk("post_rst_rd", rd, 96'd0);
        chk("post_rst_pend", 96'(pend_cnt), 96'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
